// File: rtl/gate_identifier_if.sv
// rtl/gate_identifier_if.sv - probe bundle between the sweeper and the gate under test
interface gate_identifier_if;
    logic dut_a;
    logic dut_b;
    logic dut_y;

    modport master (output dut_a, output dut_b, input dut_y);
    modport slave  (input dut_a, input dut_b, output dut_y);
endinterface

// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - truth-table sweeper that identifies a 2-input gate
module gate_identifier #(
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    gate_identifier_if.master        probe,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               truth,
    output logic [2:0]               gate_code,
    output logic                     valid_gate
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] truth_q, truth_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] cap_upd;

    // Returns {valid, code}; anything outside the six library gates is code 6.
    function automatic logic [3:0] decode(input logic [3:0] t);
        logic [3:0] r;
        case (t)
            4'b1110: r = {1'b1, 3'd0};
            4'b1000: r = {1'b1, 3'd1};
            4'b0111: r = {1'b1, 3'd2};
            4'b0001: r = {1'b1, 3'd3};
            4'b0110: r = {1'b1, 3'd4};
            4'b1001: r = {1'b1, 3'd5};
            default: r = {1'b0, 3'd6};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        truth_d = truth_q;
        code_d  = code_q;
        valid_d = valid_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cap_upd = cap_q;
        cap_upd[idx_q] = probe.dut_y;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    cap_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                busy_d     = 1'b1;
                {a_d, b_d} = idx_q;
                if (cnt_q < SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd0;
                    cap_d = cap_upd;
                    if (idx_q == 2'd3) begin
                        // Results are published from cap_upd so the last bit lands in the same edge.
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        {a_d, b_d} = 2'b00;
                        truth_d    = cap_upd;
                        {valid_d, code_d} = decode(cap_upd);
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            cap_q   <= 4'd0;
            truth_q <= 4'd0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            truth_q <= truth_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign probe.dut_a = a_q;
    assign probe.dut_b = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth       = truth_q;
    assign gate_code   = code_q;
    assign valid_gate  = valid_q;

endmodule

// File: tb/tb_gate_identifier.sv
// tb/tb_gate_identifier.sv - self-checking bench for gate_identifier
module tb_gate_identifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel0 = 1'b0;
    logic pipe = 1'b0;
    logic [3:0] tt = 4'b0000;

    always #5 clk = ~clk;

    gate_identifier_if if2 ();
    gate_identifier_if if0 ();

    logic busy2, done2, valid2, busy0, done0, valid0;
    logic [3:0] truth2, truth0;
    logic [2:0] code2, code0;
    logic start2, start0;
    logic p2_1 = 1'b0, p2_2 = 1'b0, p0_1 = 1'b0, p0_2 = 1'b0;

    assign start2 = start & ~sel0;
    assign start0 = start & sel0;

    gate_identifier #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .probe(if2.master),
        .busy(busy2), .done(done2), .truth(truth2), .gate_code(code2), .valid_gate(valid2)
    );
    gate_identifier #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .probe(if0.master),
        .busy(busy0), .done(done0), .truth(truth0), .gate_code(code0), .valid_gate(valid0)
    );

    // Gate under test: either a combinational table or an AND with two pipeline stages.
    always @(posedge clk) begin
        p2_1 <= if2.dut_a & if2.dut_b;
        p2_2 <= p2_1;
        p0_1 <= if0.dut_a & if0.dut_b;
        p0_2 <= p0_1;
    end
    assign if2.dut_y = pipe ? p2_2 : tt[{if2.dut_a, if2.dut_b}];
    assign if0.dut_y = pipe ? p0_2 : tt[{if0.dut_a, if0.dut_b}];

    wire       m_done  = sel0 ? done0 : done2;
    wire       m_busy  = sel0 ? busy0 : busy2;
    wire       m_valid = sel0 ? valid0 : valid2;
    wire [3:0] m_truth = sel0 ? truth0 : truth2;
    wire [2:0] m_code  = sel0 ? code0 : code2;
    wire [1:0] m_stim  = sel0 ? {if0.dut_a, if0.dut_b} : {if2.dut_a, if2.dut_b};

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference decode: position of the table in the library list, else 6.
    function automatic int ref_code(input logic [3:0] t);
        logic [3:0] lib [6];
        lib = '{4'b1110, 4'b1000, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        for (int k = 0; k < 6; k++) if (lib[k] == t) return k;
        return 6;
    endfunction

    task automatic sweep(input string nm, input int s, input logic [3:0] et, input int ec, input int ev);
        int hold, done_cyc, stim_err;
        hold = s + 1;
        done_cyc = -1;
        stim_err = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            if (m_done) begin
                done_cyc = c;
                break;
            end
            if (c <= 4 * hold) begin
                if (m_busy !== 1'b1) stim_err++;
                if (m_stim !== 2'((c - 1) / hold)) stim_err++;
            end
            tick();
        end
        chk({nm, "_stim"}, stim_err, 0);
        chk({nm, "_done_cycle"}, done_cyc, 4 * hold + 1);
        chk({nm, "_busy_at_done"}, int'(m_busy), 0);
        chk({nm, "_truth"}, int'(m_truth), int'(et));
        chk({nm, "_code"}, int'(m_code), ec);
        chk({nm, "_valid"}, int'(m_valid), ev);
        tick();
    endtask

    typedef struct {
        string      nm;
        logic [3:0] tt;
        logic [3:0] et;
        int         ec;
        int         ev;
    } vec_t;

    vec_t tab [10];

    initial begin
        int dones, last, dcyc, ok;
        logic [3:0] r;

        tab[0] = '{"xor",    4'b0110, 4'b0110, 4, 1};
        tab[1] = '{"or",     4'b1110, 4'b1110, 0, 1};
        tab[2] = '{"and",    4'b1000, 4'b1000, 1, 1};
        tab[3] = '{"nand",   4'b0111, 4'b0111, 2, 1};
        tab[4] = '{"nor",    4'b0001, 4'b0001, 3, 1};
        tab[5] = '{"xnor",   4'b1001, 4'b1001, 5, 1};
        tab[6] = '{"const1", 4'b1111, 4'b1111, 6, 0};
        tab[7] = '{"const0", 4'b0000, 4'b0000, 6, 0};
        tab[8] = '{"buf_a",  4'b1100, 4'b1100, 6, 0};
        tab[9] = '{"inhib",  4'b0100, 4'b0100, 6, 0};

        #2;
        chk("rst_busy", int'(busy2 | busy0), 0);
        chk("rst_done", int'(done2 | done0), 0);
        chk("rst_truth", int'(truth2 | truth0), 0);
        chk("rst_code", int'(code2 | code0), 0);
        chk("rst_valid", int'(valid2 | valid0), 0);
        chk("rst_stim", int'({if2.dut_a, if2.dut_b, if0.dut_a, if0.dut_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            tt = tab[i].tt;
            sel0 = 1'b0;
            sweep({tab[i].nm, "_s2"}, 2, tab[i].et, tab[i].ec, tab[i].ev);
            sel0 = 1'b1;
            sweep({tab[i].nm, "_s0"}, 0, tab[i].et, tab[i].ec, tab[i].ev);
        end

        pipe = 1'b1;
        sel0 = 1'b0;
        sweep("pipe_and_s2", 2, 4'b1000, 1, 1);
        sel0 = 1'b1;
        sweep("pipe_and_s0", 0, 4'b0000, 6, 0);
        pipe = 1'b0;

        for (int i = 0; i < 16; i++) begin
            r = 4'($urandom);
            tt = r;
            sel0 = 1'($urandom);
            sweep("rand", sel0 ? 0 : 2, r, ref_code(r), ref_code(r) < 6 ? 1 : 0);
        end

        // Reset in the middle of a sweep, while vector 2 is on the stimulus.
        sel0 = 1'b0;
        tt = 4'b1001;
        sweep("pre_rst_xnor", 2, 4'b1001, 5, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("mid_idx2_stim", int'(m_stim), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(m_busy), 0);
        chk("async_rst_stim", int'(m_stim), 0);
        chk("async_rst_truth", int'(m_truth), 0);
        chk("async_rst_code", int'(m_code), 0);
        chk("async_rst_valid", int'(m_valid), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_done) dones++;
        end
        chk("no_done_after_rst", dones, 0);

        // Restart with extra start pulses while busy.
        dones = 0;
        dcyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 31; c++) begin
            if (m_done) begin
                dones++;
                dcyc = c;
            end
            start = (c == 3 || c == 6 || c == 9);
            tick();
        end
        start = 1'b0;
        chk("restart_done_count", dones, 1);
        chk("restart_done_cycle", dcyc, 13);
        chk("restart_code", int'(m_code), 5);

        // Start held high, NAND, SETTLE = 0.
        sel0 = 1'b1;
        tt = 4'b0111;
        dones = 0;
        last = -1;
        ok = 0;
        start = 1'b1;
        for (int c = 1; c < 61; c++) begin
            tick();
            if (m_done) begin
                dones++;
                if (m_code != 3'd2) ok++;
                if (last < 0 ? (c != 5) : (c - last != 6)) ok++;
                last = c;
            end
            start = (c < 40);
        end
        start = 1'b0;
        chk("held_start_period_code_errs", ok, 0);
        chk("held_start_done_count", dones, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got %0d checks expected completion", n_total);
        $fatal(1);
    end

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential truth-table sweeper that identifies an unknown 2-input logic gate. It drives all four input combinations onto the gate under test and waits a programmable settle time for each. It samples the gate output and decodes the resulting 4-bit truth table into a gate code. It is the checking end of our mux-built gate library: the library builds OR/AND/NAND/NOR/XOR/XNOR from 2:1 muxes, and this block determines which of those functions a connected circuit actually implements.

## Interface

Parameters:
- `SETTLE`, default 2: extra hold cycles per input vector before sampling. Legal range 0..15.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a sweep. Sampled only in IDLE.
- `dut_a`, output, 1: stimulus `a` driven to the gate under test.
- `dut_b`, output, 1: stimulus `b` driven to the gate under test.
- `dut_y`, input, 1: output of the gate under test.
- `busy`, output, 1: high while a sweep is in progress (state WAIT).
- `done`, output, 1: one-cycle pulse when the results are updated.
- `truth`, output, 4: captured truth table. `truth[i]` = `dut_y` with `{dut_a,dut_b}` = i.
- `gate_code`, output, 3: decoded function: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 unknown. Value 7 is never produced.
- `valid_gate`, output, 1: high when `gate_code` is 0..5.

## Operation

- States: IDLE, WAIT, DONE. Internal registers:
  - vector index `idx` (2 bits)
  - settle counter `cnt` (4 bits)
  - capture register `cap` (4 bits)
- IDLE:
  - `dut_a` = `dut_b` = 0, `busy` = 0, `done` = 0.
  - When `start` = 1, go to WAIT with `idx` = 0, `cnt` = 0, `cap` = 0.
- WAIT:
  - `{dut_a,dut_b}` = `idx`, registered outputs. `busy` = 1.
  - If `cnt` < SETTLE: increment `cnt`.
  - If `cnt` = SETTLE: set `cap[idx]` = `dut_y` and `cnt` = 0.
    - If `idx` = 3: go to DONE.
    - Otherwise: increment `idx`.
- DONE, one cycle:
  - `done` = 1. Stimulus returns to 00.
  - Always go to IDLE next.
- Result update happens on the edge entering DONE, simultaneously:
  - `truth` ← final `cap`, including the bit captured at that edge.
  - `gate_code` and `valid_gate` ← decode of that same value.
- Decode of truth[3:0]:
  - 1110 → 0 (OR)
  - 1000 → 1 (AND)
  - 0111 → 2 (NAND)
  - 0001 → 3 (NOR)
  - 0110 → 4 (XOR)
  - 1001 → 5 (XNOR)
  - Anything else → 6 with `valid_gate` = 0. This covers constants, buffers, inverters and inhibit functions.
- `truth`, `gate_code` and `valid_gate` hold their values until the next DONE entry or reset. They are not cleared by `start`.
- `start` in WAIT or DONE is ignored. If `start` is held high continuously, a new sweep begins on the edge after DONE returns to IDLE.
- Reset (`rst_n` low, any time, including mid-sweep) takes effect immediately, without waiting for a clock edge:
  - State becomes IDLE; `idx`, `cnt` and `cap` become 0.
  - `dut_a` = `dut_b` = 0, `busy` = 0, `done` = 0.
  - `truth` = 0000, `gate_code` = 0, `valid_gate` = 0.
  - A partial sweep is discarded and never reported.

## Timing

- Edge 0 samples `start` = 1 in IDLE.
- From cycle 1, `busy` = 1 and stimulus = 00.
- Each vector is held for SETTLE+1 cycles. `dut_y` is sampled at the last edge of that hold, and the next vector appears in the following cycle.
- WAIT lasts 4·(SETTLE+1) cycles. `done` is high in cycle 4·(SETTLE+1)+1, and `busy` is low in that cycle.
  - SETTLE = 2: `done` in cycle 13.
  - SETTLE = 0: `done` in cycle 5.
- Back-to-back sweeps: with `start` held high, the minimum period is 4·(SETTLE+1)+2 cycles (WAIT + DONE + one IDLE cycle).
- The gate under test must produce a valid `dut_y` within SETTLE cycles after the vector changes. This includes registered or pipelined gates of latency ≤ SETTLE.
- All outputs are registered. There is no combinational path from `dut_y` or `start` to any output.

## Test plan

- Loopback to a combinational XOR, SETTLE = 2: pulse `start`.
  - Expect stimulus sequence 00,01,10,11 with 3 cycles each.
  - Expect `done` in cycle 13, `truth` = 0110, `gate_code` = 4, `valid_gate` = 1.
- Sweep each of OR/AND/NAND/NOR/XNOR in turn: expect codes 0,1,2,3,5 with truth 1110/1000/0111/0001/1001, all with `valid_gate` = 1.
- Gate under test tied to constant 1: expect `truth` = 1111, `gate_code` = 6, `valid_gate` = 0.
- AND gate with a 2-cycle output pipeline:
  - SETTLE = 2: expect `gate_code` = 1.
  - SETTLE = 0: expect `truth` = 0000 (stale samples), `gate_code` = 6.
- Reset mid-sweep, then `start` pulses:
  - Assert `rst_n` low while `idx` = 2. Expect all outputs 0 immediately and no `done`.
  - Restart the sweep. While `busy`, pulse `start` 3 more times. Expect exactly one `done`, at the nominal cycle.
- `start` held high for 40 cycles, NAND gate under test, SETTLE = 0: expect `done` every 6 cycles, each reporting `gate_code` = 2.
